cover_toggle_sched: RTL and testbench
=====================================

# cover_toggle_sched

Scheduler that collects toggle-coverage hit vectors from several toggle-point groups and serialises them into a single stream of cover indices, one per handshake. It sits between the per-signal toggle-point instances and the single coverage sink (DPI `v_cover_toggle` caller or formal monitor), so the sink sees at most one event per cycle. Hits are OR-accumulated, so none are lost under back-pressure. Sources are served round-robin with a per-grant snapshot, so no source can starve another.

## Interface
- `NUM_SRC`, 4: number of toggle groups.
- `WIDTH`, 29: hit bits per group.
- `COVER_INDEX`, 0: global index of group 0 bit 0.
- `COVER_TOTAL`, 8940: total cover points; used only for the index range check.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `src_valid`  in  NUM_SRC*WIDTH  per-cycle hit vector; group s occupies bits [s*WIDTH +: WIDTH].
- `out_valid`  out  1  `out_index` holds a pending event.
- `out_ready`  in  1  sink accepts the event this cycle.
- `out_index`  out  64  `COVER_INDEX + s*WIDTH + b`.
- `busy`  out  1  state is EMIT or any pending bit is set.

## Operation
- Storage:
  - `pending[s][b]`: accumulated, not yet emitted hits.
  - `gmask[WIDTH]`: snapshot of the granted source's pending bits.
  - `cur`: granted source.
  - `rr_ptr`: round-robin start point.
- Accumulate: every cycle with `reset` low, `pending[s][b]` is set when `src_valid[s*WIDTH+b]` is 1. `src_valid` is ignored while `reset` is high.
- FSM has two states.
  - IDLE:
    - If any `pending` bit is set, select the first source s with a nonzero pending vector, searching from `rr_ptr` upward with wrap.
    - Latch `cur=s` and `gmask=pending[s]`, then go to EMIT.
    - Otherwise stay in IDLE.
  - EMIT:
    - `out_valid=1`; `b` = lowest set bit of `gmask`.
    - On `out_valid&&out_ready`, clear `gmask[b]` and `pending[cur][b]`.
    - If `gmask` is now zero, go to IDLE and set `rr_ptr=(cur+1)%NUM_SRC`.
- Set/clear collision: a new hit on `pending[cur][b]` in the same cycle as its clear wins, leaving the bit set. That bit is re-emitted on a later grant.
- Snapshot rule: hits arriving on `cur` during EMIT go to `pending` only, never to `gmask`. They are served on the next grant to `cur`.
- Width rules:
  - Index arithmetic is 64-bit unsigned.
  - Lowest-set-bit selection is a priority encoder over `WIDTH`.
  - `rr_ptr` and `cur` are `$clog2(NUM_SRC)` bits, minimum 1.
- Reset mid-operation:
  - Clears `pending`, `gmask`, `cur`, `rr_ptr` and the seen bitmap.
  - Returns to IDLE and drops any un-acknowledged event.
- Simulation check (`ifndef SYNTHESIS`): error if `COVER_INDEX+NUM_SRC*WIDTH > COVER_TOTAL`.

## Timing
- Reset values: `out_valid=0`, `out_index=0`, `busy=0`, state IDLE.
- Latency: a hit at edge t sets `pending` at t+1. IDLE grants at t+1, and `out_valid` rises at t+2 (2 cycles minimum).
- Throughput: one index per cycle within a grant. One IDLE bubble cycle occurs between grants.
- Back-pressure:
  - `out_index` and `out_valid` are held stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake, except on reset.
- `out_ready` may be high while `out_valid` is low; it has no effect.
- Fairness: each grant emits at most `WIDTH` events. Worst-case wait for a source is `(NUM_SRC-1)*(WIDTH+1)` handshake cycles.
- Registered outputs only; no combinational path from `src_valid` or `out_ready` to outputs.

## Configuration
- `COVER_TOGGLE_DEDUP_EN` defined:
  - A seen bitmap `seen[s][b]` (`NUM_SRC*WIDTH` flops, cleared only by reset) is set on each handshake.
  - Accumulate becomes `pending |= src_valid & ~seen`, so each index is emitted at most once after reset.
  - The collision case above cannot re-arm a bit.
- Not defined:
  - No seen bitmap.
  - Every re-hit after a clear is emitted again.

## Test plan
Configuration for all scenarios: NUM_SRC=4, WIDTH=29, COVER_INDEX=100.
- Single hit: pulse `src_valid` bit 2*29+5 for one cycle, `out_ready`=1 → exactly one event `out_index`=163, `out_valid` high 2 cycles after the pulse, then idle with `busy`=0.
- Burst ordering: group 1 bits {0,3,28} hit together → indices 129, 132, 157 in consecutive cycles.
- Round-robin: groups 0 and 3 bit 0 both held high continuously, dedup off → grants alternate group 0 (100) then group 3 (187), repeating; no starvation.
- Back-pressure: group 0 bits {1,2} hit, `out_ready`=0 for 5 cycles → `out_index`=101 stable and `out_valid`=1 throughout; then 101 and 102 emitted, nothing lost.
- Collision/dedup: re-hit bit 0 of group 0 in the cycle index 100 is accepted → with dedup off, 100 is emitted again on a later grant; with `COVER_TOGGLE_DEDUP_EN`, it is emitted once only.
- Reset mid-burst: assert `reset` during EMIT with 3 bits of `gmask` outstanding → next cycle `out_valid`=0, `busy`=0; no stale indices after reset deasserts.

Source files
------------

// File: rtl/cover_toggle_sched.sv
// cover_toggle_sched: OR-accumulates per-group toggle hits and serialises them round-robin into one cover-index stream.
// Optional macro COVER_TOGGLE_DEDUP_EN adds a seen bitmap so each index is emitted at most once after reset.
module cover_toggle_sched #(
    parameter int          NUM_SRC     = 4,
    parameter int          WIDTH       = 29,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter logic [63:0] COVER_TOTAL = 64'd8940
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_index,
    output logic                     busy
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW:0] NSRC = (SW+1)'(NUM_SRC);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] w_pending [NUM_SRC];
    logic [WIDTH-1:0] r_gmask;
    logic [WIDTH-1:0] w_gmask_next;
    logic [SW-1:0]    r_cur;
    logic [SW-1:0]    w_cur_next;
    logic [SW-1:0]    r_rr_ptr;
    logic [SW-1:0]    w_rr_ptr_next;
    logic [63:0]      r_out_index;
    logic             r_busy;

    logic             w_fire;
    logic [BW-1:0]    w_bit;
    logic [BW-1:0]    w_bit_next;
    logic [WIDTH-1:0] w_clr_onehot;
    logic [NUM_SRC-1:0] w_nz;
    logic [NUM_SRC-1:0] w_nz_next;
    logic [NUM_SRC-1:0] w_nz_rot;
    logic             w_grant_found;
    logic [SW-1:0]    w_grant_ofs;
    logic [SW:0]      w_grant_sum;
    logic [SW-1:0]    w_grant_src;

    function automatic logic [BW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [BW-1:0] pos;
        pos = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) pos = BW'(i);
        end
        return pos;
    endfunction

    assign out_valid    = (r_state == EMIT);
    assign out_index    = r_out_index;
    assign busy         = r_busy;
    assign w_fire       = (r_state == EMIT) && out_ready;
    assign w_bit        = lowest_set(r_gmask);
    assign w_clr_onehot = w_fire ? (WIDTH'(1) << w_bit) : '0;
    assign w_bit_next   = lowest_set(w_gmask_next);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [WIDTH-1:0] r_pend;
            logic [WIDTH-1:0] w_clr;
            logic [WIDTH-1:0] w_hit;
            logic [WIDTH-1:0] w_pend_next;

            assign w_clr = (r_cur == SW'(gi)) ? w_clr_onehot : '0;
`ifdef COVER_TOGGLE_DEDUP_EN
            logic [WIDTH-1:0] r_seen;
            // Masking with w_clr too keeps a same-cycle re-hit from re-arming the bit being retired.
            assign w_hit = src_valid[gi*WIDTH +: WIDTH] & ~(r_seen | w_clr);

            always_ff @(posedge clock) begin
                if (reset) r_seen <= '0;
                else       r_seen <= r_seen | w_clr;
            end
`else
            assign w_hit = src_valid[gi*WIDTH +: WIDTH];
`endif
            // New hits win over the handshake clear.
            assign w_pend_next   = (r_pend & ~w_clr) | w_hit;
            assign w_pending[gi] = r_pend;
            assign w_nz[gi]      = |r_pend;
            assign w_nz_next[gi] = |w_pend_next;

            always_ff @(posedge clock) begin
                if (reset) r_pend <= '0;
                else       r_pend <= w_pend_next;
            end
        end
    endgenerate

    // Round-robin search: rotate the nonzero flags so rr_ptr lands at bit 0, then take the lowest.
    assign w_nz_rot = NUM_SRC'({w_nz, w_nz} >> r_rr_ptr);

    always_comb begin
        w_grant_found = |w_nz;
        w_grant_ofs   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_nz_rot[i]) w_grant_ofs = SW'(i);
        end
        w_grant_sum = {1'b0, r_rr_ptr} + {1'b0, w_grant_ofs};
        w_grant_src = (w_grant_sum >= NSRC) ? SW'(w_grant_sum - NSRC) : SW'(w_grant_sum);
    end

    always_comb begin
        w_state_next  = r_state;
        w_gmask_next  = r_gmask;
        w_cur_next    = r_cur;
        w_rr_ptr_next = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_grant_found) begin
                    w_cur_next   = w_grant_src;
                    w_gmask_next = w_pending[w_grant_src];
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_fire) begin
                    w_gmask_next = r_gmask & ~w_clr_onehot;
                    if (w_gmask_next == '0) begin
                        w_state_next  = IDLE;
                        w_rr_ptr_next = (r_cur == SW'(NUM_SRC - 1)) ? '0 : r_cur + SW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gmask     <= '0;
            r_cur       <= '0;
            r_rr_ptr    <= '0;
            r_out_index <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_gmask  <= w_gmask_next;
            r_cur    <= w_cur_next;
            r_rr_ptr <= w_rr_ptr_next;
            r_busy   <= (w_state_next == EMIT) || (|w_nz_next);
            if (w_state_next == EMIT) begin
                r_out_index <= COVER_INDEX + 64'(w_cur_next) * 64'(WIDTH) + 64'(w_bit_next);
            end
        end
    end

`ifndef SYNTHESIS
    localparam bit RANGE_OK = (COVER_INDEX + 64'(NUM_SRC * WIDTH)) <= COVER_TOTAL;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (RANGE_OK)
            else $error("cover_toggle_sched: COVER_INDEX+NUM_SRC*WIDTH exceeds COVER_TOTAL");
        end
    end
`endif

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Bench for cover_toggle_sched: set-based reference model checked every cycle plus literal per-scenario expectations.
module tb_cover_toggle_sched;
    localparam int          NUM_SRC = 4;
    localparam int          WIDTH   = 29;
    localparam logic [63:0] CIDX    = 64'd100;

    logic                     clk;
    logic                     reset;
    logic [NUM_SRC*WIDTH-1:0] src_valid;
    logic                     out_valid;
    logic                     out_ready;
    logic [63:0]              out_index;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 0;

    logic [63:0] ev_log[$];
    int          ev_cyc[$];

    cover_toggle_sched #(
        .NUM_SRC(NUM_SRC), .WIDTH(WIDTH), .COVER_INDEX(CIDX), .COVER_TOTAL(64'd8940)
    ) dut (
        .clock(clk), .reset(reset), .src_valid(src_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pending sets, per-grant queue of indices, round-robin pointer.
    bit          m_pend [NUM_SRC][WIDTH];
    bit          m_seen [NUM_SRC][WIDTH];
    logic [63:0] m_q[$];
    bit          m_grant;
    int          m_cur;
    int          m_rr;

    always @(posedge clk) begin
        logic [63:0] idx;
        int          b;
        int          s;
        bit          allow;
        cyc++;
        if (reset) begin
            foreach (m_pend[i, j]) begin
                m_pend[i][j] = 0;
                m_seen[i][j] = 0;
            end
            m_q.delete();
            m_grant = 0;
            m_cur   = 0;
            m_rr    = 0;
        end else begin
            if (m_grant) begin
                if (out_ready) begin
                    idx = m_q.pop_front();
                    b   = int'(idx - CIDX) - m_cur * WIDTH;
                    m_pend[m_cur][b] = 0;
                    m_seen[m_cur][b] = 1;
                    if (m_q.size() == 0) begin
                        m_grant = 0;
                        m_rr    = (m_cur + 1) % NUM_SRC;
                    end
                end
            end else begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    s = (m_rr + k) % NUM_SRC;
                    if (!m_grant) begin
                        for (int j = 0; j < WIDTH; j++)
                            if (m_pend[s][j]) m_q.push_back(CIDX + 64'(s * WIDTH + j));
                        if (m_q.size() != 0) begin
                            m_grant = 1;
                            m_cur   = s;
                        end
                    end
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    allow = 1;
`ifdef COVER_TOGGLE_DEDUP_EN
                    allow = !m_seen[i][j];
`endif
                    if (src_valid[i*WIDTH + j] && allow) m_pend[i][j] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit any;
        if (started) begin
            any = m_grant;
            foreach (m_pend[i, j]) if (m_pend[i][j]) any = 1;
            check("model_valid", {63'd0, out_valid}, {63'd0, m_grant});
            if (m_grant) check("model_index", out_index, m_q[0]);
            check("model_busy", {63'd0, busy}, {63'd0, any});
            if (out_valid && out_ready && !reset) begin
                ev_log.push_back(out_index);
                ev_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1;
        src_valid = '0;
        tick();
        tick();
        reset = 0;
        ev_log.delete();
        ev_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        tick();
        while ((busy || out_valid) && k < 300) begin
            tick();
            k++;
        end
        n_cmp++;
        if (busy || out_valid) begin
            n_err++;
            $display("FAIL %s_timeout: busy=%0b valid=%0b, expected idle", name, busy, out_valid);
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_err++;
            $display("FAIL %s_timeout: out_valid=0, expected 1", name);
        end
    endtask

    initial begin
        int c0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset     = 1;
        out_ready = 0;
        src_valid = '0;
        tick();
        tick();
        reset   = 0;
        started = 1;
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_index", out_index, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // Single hit on group 2 bit 5.
        do_reset();
        out_ready = 1;
        src_valid[2*WIDTH + 5] = 1'b1;
        c0 = cyc;
        tick();
        src_valid = '0;
        wait_idle("single");
        check("single_count", 64'(ev_log.size()), 64'd1);
        check("single_index", ev_log[0], 64'd163);
        check("single_latency", 64'(ev_cyc[0] - c0), 64'd2);
        $display("single hit: %0d events, first=%0d", ev_log.size(), ev_log[0]);

        // Burst on group 1 bits 0, 3, 28.
        do_reset();
        src_valid[1*WIDTH + 0]  = 1'b1;
        src_valid[1*WIDTH + 3]  = 1'b1;
        src_valid[1*WIDTH + 28] = 1'b1;
        tick();
        src_valid = '0;
        wait_idle("burst");
        check("burst_count", 64'(ev_log.size()), 64'd3);
        check("burst_idx0", ev_log[0], 64'd129);
        check("burst_idx1", ev_log[1], 64'd132);
        check("burst_idx2", ev_log[2], 64'd157);
        check("burst_back2back", 64'(ev_cyc[2] - ev_cyc[0]), 64'd2);
        $display("burst: %0d events", ev_log.size());

        // Round robin: groups 0 and 3 bit 0 held high.
        do_reset();
        src_valid[0]         = 1'b1;
        src_valid[3*WIDTH]   = 1'b1;
        repeat (12) tick();
        src_valid = '0;
        wait_idle("rr");
`ifdef COVER_TOGGLE_DEDUP_EN
        check("rr_count", 64'(ev_log.size()), 64'd2);
`else
        check("rr_min_events", {63'd0, ev_log.size() >= 4}, 64'd1);
`endif
        foreach (ev_log[i]) check("rr_alternate", ev_log[i], (i % 2 == 0) ? 64'd100 : 64'd187);
        $display("round robin: %0d events", ev_log.size());

        // Back-pressure on group 0 bits 1, 2.
        do_reset();
        out_ready = 0;
        src_valid[1] = 1'b1;
        src_valid[2] = 1'b1;
        tick();
        src_valid = '0;
        wait_valid("bp");
        repeat (5) begin
            tick();
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_index", out_index, 64'd101);
        end
        out_ready = 1;
        wait_idle("bp");
        check("bp_count", 64'(ev_log.size()), 64'd2);
        check("bp_idx0", ev_log[0], 64'd101);
        check("bp_idx1", ev_log[1], 64'd102);
        $display("back-pressure: %0d events", ev_log.size());

        // Collision: re-hit group 0 bit 0 in the handshake cycle of index 100.
        do_reset();
        src_valid[0] = 1'b1;
        tick();
        src_valid = '0;
        wait_valid("coll");
        src_valid[0] = 1'b1;
        tick();
        src_valid = '0;
        wait_idle("coll");
`ifdef COVER_TOGGLE_DEDUP_EN
        check("coll_count", 64'(ev_log.size()), 64'd1);
`else
        check("coll_count", 64'(ev_log.size()), 64'd2);
        check("coll_idx1", ev_log[1], 64'd100);
`endif
        check("coll_idx0", ev_log[0], 64'd100);
        $display("collision: %0d events", ev_log.size());

        // Reset while 3 bits of the grant are still outstanding.
        do_reset();
        src_valid[2*WIDTH +: 4] = 4'hF;
        tick();
        src_valid = '0;
        wait_valid("rst");
        tick();
        reset = 1;
        tick();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 0;
        repeat (10) tick();
        check("rst_count", 64'(ev_log.size()), 64'd1);
        check("rst_idx0", ev_log[0], 64'd158);
        $display("reset mid-burst: %0d events", ev_log.size());

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
